// File: rtl/dport_source.sv
// dport_source: byte stream source for a system input port.
//
// A producer appends bytes through the load port. The consumer requests one
// byte at a time on dport_read and receives it on dport_in with dport_valid
// one cycle later. The bytes sit in a circular FIFO of DEPTH entries. A byte
// loaded with load_last marks the end of the stream. After that byte has been
// delivered the source reports done, and it stays done until reset.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   load_data    byte to append to the stream
//   load_write   append load_data this cycle
//   load_last    qualifies load_write; marks the byte as end-of-stream
//   load_full    buffer holds DEPTH bytes
//   dport_read   request the next byte
//   dport_in     byte for the previous-cycle request (holds when idle)
//   dport_valid  dport_in carries a real stream byte; one-cycle pulse
//   empty        buffer holds zero bytes
//   count        number of bytes currently buffered
//   underflow    sticky: a read found the buffer empty
//   overflow     sticky: a load was dropped
//   done         the end-of-stream byte has been delivered
//
// States
//   FILL   | accepting loads; no end-of-stream byte seen yet
//   CLOSED | end-of-stream byte buffered; loads dropped, reads served
//   DONE   | end-of-stream byte delivered; loads dropped, reads underflow

module dport_source #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               load_data,
  input  logic                     load_write,
  input  logic                     load_last,
  output logic                     load_full,
  input  logic                     dport_read,
  output logic [7:0]               dport_in,
  output logic                     dport_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow,
  output logic                     overflow,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] CLOSED = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] last_ptr;
  logic [1:0]    state;

  logic read_served;
  logic load_accept;
  logic eos_read;

  // A read is served only from bytes that are already buffered. There is no
  // bypass from load_data. DONE forces an underflow even though the buffer
  // is necessarily empty by then.
  always_comb begin
    read_served = dport_read && (count != '0) && (state != DONE);
    // A full buffer can still take a byte when a read frees a slot in the
    // same cycle.
    load_accept = load_write && (state == FILL) &&
                  ((count != FULL_CNT) || read_served);
    // No load is accepted after the end-of-stream byte. So once that byte
    // reaches the head, it is the last byte in the buffer.
    eos_read    = read_served && (state == CLOSED) && (head == last_ptr);
  end

  assign load_full = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign done      = (state == DONE);

  // Storage has no reset. Stale entries cannot be reached because reset
  // clears both pointers and the count.
  always_ff @(posedge clk) begin
    if (!reset && load_accept) begin
      mem[tail] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      head        <= '0;
      tail        <= '0;
      last_ptr    <= '0;
      count       <= '0;
      dport_in    <= 8'h00;
      dport_valid <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (load_accept) begin
        tail <= tail + 1'b1;
        if (load_last) begin
          state    <= CLOSED;
          last_ptr <= tail;
        end
      end else if (load_write) begin
        overflow <= 1'b1;
      end

      // With a simultaneous write to the same slot (full buffer), mem[head]
      // still yields the old head byte.
      if (read_served) begin
        head        <= head + 1'b1;
        dport_in    <= mem[head];
        dport_valid <= 1'b1;
        if (eos_read) begin
          state <= DONE;
        end
      end else begin
        dport_valid <= 1'b0;
        if (dport_read) begin
          dport_in  <= 8'h00;
          underflow <= 1'b1;
        end
      end

      case ({load_accept, read_served})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dport_source.sv
// Directed bench for dport_source. A small queue model predicts which loads
// are accepted and which reads are served. Bytes from served reads are pushed
// to a scoreboard queue and popped when dport_valid should appear.
module tb_dport_source;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] load_data = 8'h00;
  logic       load_write = 1'b0;
  logic       load_last = 1'b0;
  logic       load_full;
  logic       dport_read = 1'b0;
  logic [7:0] dport_in;
  logic       dport_valid;
  logic       empty;
  logic [8:0] count;
  logic       underflow;
  logic       overflow;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  int         m_state = 0;
  logic       m_unf = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_in = 8'h00;

  dport_source #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .load_data(load_data),
    .load_write(load_write),
    .load_last(load_last),
    .load_full(load_full),
    .dport_read(dport_read),
    .dport_in(dport_in),
    .dport_valid(dport_valid),
    .empty(empty),
    .count(count),
    .underflow(underflow),
    .overflow(overflow),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input logic exp_valid);
    chk("dport_valid", {31'd0, dport_valid}, {31'd0, exp_valid});
    chk("dport_in", {24'd0, dport_in}, {24'd0, m_in});
    chk("count", {23'd0, count}, model.size());
    chk("empty", {31'd0, empty}, {31'd0, model.size() == 0});
    chk("load_full", {31'd0, load_full}, {31'd0, model.size() == DEPTH});
    chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("done", {31'd0, done}, {31'd0, m_state == 2});
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic l, input logic r);
    int   sz;
    logic served;
    logic accept;
    sz     = model.size();
    served = r && (sz > 0) && (m_state != 2);
    accept = w && (m_state == 0) && ((sz < DEPTH) || served);
    load_write = w;
    load_data  = d;
    load_last  = l;
    dport_read = r;
    if (served) begin
      if (m_state == 1 && sz == 1) m_state = 2;
      exp_q.push_back(model.pop_front());
    end else if (r) begin
      m_unf = 1'b1;
    end
    if (accept) begin
      model.push_back(d);
      if (l) m_state = 1;
    end else if (w) begin
      m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    load_write = 1'b0;
    load_last  = 1'b0;
    dport_read = 1'b0;
    if (served) m_in = exp_q.pop_front();
    else if (r) m_in = 8'h00;
    check_outputs(served);
  endtask

  task automatic do_reset(input logic w, input logic r);
    reset      = 1'b1;
    load_write = w;
    load_data  = 8'hEE;
    load_last  = 1'b0;
    dport_read = r;
    @(posedge clk);
    #1;
    load_write = 1'b0;
    dport_read = 1'b0;
    model.delete();
    exp_q.delete();
    m_state = 0;
    m_unf   = 1'b0;
    m_ovf   = 1'b0;
    m_in    = 8'h00;
    check_outputs(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset(1'b0, 1'b0);

    // Read an empty buffer, then recover with one byte.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset wins over a load and a read in the same cycle.
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);

    // Short stream with an end-of-stream marker.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    do_reset(1'b0, 1'b0);

    // Fill completely, overflow once, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset(1'b0, 1'b0);

    // Simultaneous load and read on a partly filled buffer.
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b1);
    cycle(1'b1, 8'hC3, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset(1'b0, 1'b0);

    // Full buffer with a load and a read in the same cycle.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i * 3 + 1), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    do_reset(1'b0, 1'b0);

    // A load after end-of-stream is dropped; reset mid-stream recovers.
    cycle(1'b1, 8'h01, 1'b1, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    do_reset(1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dport_source.md
DPORT_SOURCE -- requirements
Module: dport_source

Interface
REQ-001 Parameter: DEPTH, default 256, number of byte entries in the stream buffer; power of two, 2..256.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 load_data  input  8  byte to append to the input stream.
REQ-005 load_write  input  1  append load_data this cycle.
REQ-006 load_last  input  1  qualifies load_write; marks the byte as end-of-stream.
REQ-007 load_full  output  1  buffer holds DEPTH bytes.
REQ-008 dport_read  input  1  system requests the next input-port byte.
REQ-009 dport_in  output  8  byte returned for the previous-cycle request.
REQ-010 dport_valid  output  1  dport_in holds a real stream byte; one-cycle pulse.
REQ-011 empty  output  1  buffer holds zero bytes.
REQ-012 count  output  log2(DEPTH)+1  bytes currently buffered.
REQ-013 underflow  output  1  sticky: a read hit an empty buffer.
REQ-014 overflow  output  1  sticky: a load was dropped.
REQ-015 done  output  1  end-of-stream byte has been delivered.

Function
REQ-016 Storage: circular FIFO, DEPTH x 8; head and tail pointers wrap modulo DEPTH; count = writes accepted - reads served.
REQ-017 Load accepted when load_write=1, state != CLOSED/DONE, and (count < DEPTH or a read is served in the same cycle).
REQ-018 Load dropped, overflow set, when load_write=1 and the buffer is full with no same-cycle read, or when state is CLOSED or DONE.
REQ-019 Read served when dport_read=1 and count > 0 at the start of the cycle; no write-to-read bypass.
REQ-020 Served read: dport_in = head byte and dport_valid = 1 on the following cycle; head advances by one.
REQ-021 Read on an empty buffer: dport_in = 8'h00, dport_valid = 0 the following cycle, underflow set; pointers unchanged.
REQ-022 Without a read request: dport_valid = 0; dport_in holds its last value.
REQ-023 Simultaneous accepted load and served read: count unchanged; both pointers advance.
REQ-024 Read latency fixed at 1 cycle; back-to-back reads every cycle deliver consecutive bytes.
REQ-025 State machine: FILL -> CLOSED on an accepted load with load_last=1.
REQ-026 CLOSED -> DONE on the cycle the end-of-stream byte is presented with dport_valid=1.
REQ-027 DONE is held until reset; done = 1 only in DONE.
REQ-028 Reads in CLOSED are served normally; reads in DONE underflow.
REQ-029 Dropped loads never change count or pointers, and never cause a state transition.
REQ-030 underflow and overflow clear only on reset.
REQ-031 load_full = (count == DEPTH); empty = (count == 0); both combinational from count.

Reset
REQ-032 While reset = 1: state = FILL, pointers = 0, count = 0, dport_in = 8'h00, dport_valid = 0, underflow = 0, overflow = 0, done = 0.
REQ-033 Reset overrides any load or read in the same cycle.
REQ-034 Buffer contents need not be cleared; stale data is unreachable after reset.
REQ-035 Reset mid-stream, including from CLOSED or DONE, discards all buffered bytes.

Verification
REQ-036 Load 8'h11, 8'h22, 8'h33 (last on 33); issue 3 reads on consecutive cycles.
  Required: dport_in 11, 22, 33 on the three following cycles with dport_valid = 1; done = 1 with the 33 cycle; empty = 1.
REQ-037 Load 256 bytes 00..FF.
  Required: load_full = 1 and count = 256.
  Then a 257th load of 8'hAA: overflow = 1, count stays 256.
  Then read all 256: bytes return 00..FF in order.
REQ-038 Read after reset with no loads.
  Required: dport_valid = 0, dport_in = 00, underflow = 1.
  Then load 8'h5A and read: 5A returned with dport_valid = 1; underflow still 1.
REQ-039 Full buffer, load 8'h77 and read in the same cycle.
  Required: load accepted, count stays 256, no overflow, head byte returned; 77 emerges after the other 255 bytes.
REQ-040 Load 8'h01 with load_last = 1, then load 8'h02.
  Required: overflow = 1, count = 1.
  Then assert reset mid-stream: all outputs return to reset values; a fresh load of 8'h02 is accepted and read back.
